tree_walker: RTL and testbench
==============================

TREE_WALKER -- requirements
Module: tree_walker

Interface
REQ-001 SHALL take parameter IDENTIFIER_SIZE, default user_tree_pkg::IDENTIFIER_SIZE, identifier width in bits.
REQ-002 SHALL take parameter MAX_NODES_PER_LEVEL, default user_tree_pkg::MAX_NODES_PER_LEVEL, number of child slots per node.
REQ-003 SHALL take parameter NODE_ADDR_SIZE, default tree_pkg::NODE_ADDR_SIZE (8), node address width in bits.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- tok_valid  in  1  identifier token offered
- tok_ready  out  1  walker can accept a token
- tok_id  in  IDENTIFIER_SIZE  identifier of the next path element
- tok_last  in  1  token ends the current path
- node_rd_en  out  1  tree memory read strobe
- node_rd_addr  out  NODE_ADDR_SIZE  tree memory read address
- node_rd_data  in  NODE_SIZE  node word, valid one cycle after node_rd_en
- match_valid  out  1  lookup result available
- match_ready  in  1  consumer accepts the result
- match_hit  out  1  1 = identifier found among children
- match_addr  out  NODE_ADDR_SIZE  matched child address on a hit; current node address on a miss

Function
REQ-005 SHALL use node word layout tree_pkg: id in bits [IDENTIFIER_SIZE-1:0], child slot k in the NODE_ADDR_SIZE field above that at offset k*NODE_ADDR_SIZE.
REQ-006 SHALL treat child address 0 as an empty slot, since the root (address 0) is never a child.
REQ-007 SHALL hold register cur_addr, the current node address, which is 0 after reset.
REQ-008 SHALL implement FSM states IDLE, FETCH, SCAN, CMP and RESP; tok_ready=1 only in IDLE.
REQ-009 IDLE: on tok_valid&tok_ready, SHALL latch tok_id and tok_last and go to FETCH.
REQ-010 FETCH: SHALL drive node_rd_en=1 and node_rd_addr=cur_addr, then go to SCAN with k=0; SCAN latches the child list from node_rd_data on entry.
REQ-011 SCAN: if slot k is empty, SHALL go to RESP as a miss; otherwise SHALL drive node_rd_en=1 with node_rd_addr=child[k] and go to CMP.
REQ-012 CMP: if the id of node_rd_data equals the latched tok_id, SHALL go to RESP as a hit with match_addr=child[k]; else if k=MAX_NODES_PER_LEVEL-1, SHALL go to RESP as a miss; else SHALL increment k and return to SCAN.
REQ-013 Latency (token accepted at edge T) SHALL be:
- hit in slot k: match_valid first high in cycle T+3+2k
- empty slot k: match_valid first high in cycle T+3+2k
- all slots full, no match: match_valid first high in cycle T+2+2*MAX_NODES_PER_LEVEL
REQ-014 RESP: match_valid, match_hit and match_addr SHALL stay stable until match_ready; on the handshake the FSM returns to IDLE.
REQ-015 On a response handshake, SHALL update cur_addr as follows:
- hit: cur_addr <= match_addr
- miss: cur_addr unchanged
- latched tok_last=1: cur_addr <= 0 (overrides both cases above)
REQ-016 A token with tok_id=0 SHALL produce a miss without changing cur_addr (unless tok_last=1).
REQ-017 node_rd_en SHALL be 0 in IDLE, CMP and RESP.

Reset
REQ-018 On rst_n low, SHALL asynchronously set state=IDLE, cur_addr=0, k=0, match_valid=0, match_hit=0, match_addr=0 and node_rd_en=0; tok_ready SHALL be 1 once reset is released.
REQ-019 Reset mid-lookup SHALL abandon the lookup; no response is produced for that token.

Configuration
REQ-020 With TREE_WALKER_STATS_EN defined, SHALL add output ports hit_count and miss_count (16 bits each), which increment on each response handshake and saturate at 16'hFFFF.
REQ-021 Without TREE_WALKER_STATS_EN, these ports and their counters SHALL NOT exist.

Structure
REQ-022 The walker FSM state enum and the node-field slice helpers SHALL live in tree_pkg; no new constants are defined locally.
REQ-023 The stats counters SHALL be a sub-module, tree_walker_stats, instantiated only under TREE_WALKER_STATS_EN.

Verification
REQ-024 Tree: root children {1,2}, node1 id 5, node2 id 7. Token 7 -> match_valid at T+5, hit=1, addr=2, cur_addr=2.
REQ-025 From cur_addr=2, whose node has no children, token 9 -> match_valid at T+3, hit=0, addr=2, cur_addr stays 2.
REQ-026 Token 5 with tok_last=1 -> hit=1, addr=1; cur_addr=0 after the handshake.
REQ-027 Hold match_ready=0 for 4 cycles -> outputs stable and tok_ready=0 throughout; the handshake then returns the FSM to IDLE.
REQ-028 Assert rst_n low during CMP -> match_valid=0, cur_addr=0, tok_ready=1 after release; the next token 5 resolves from the root.
REQ-029 With TREE_WALKER_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2; with hit_count preset to 16'hFFFF, a further hit leaves it at 16'hFFFF.

Source files
------------

// File: rtl/tree_pkg.sv
// Shared tree definitions: address width, walker state encoding and node-word field helpers.
package tree_pkg;
  localparam int NODE_ADDR_SIZE = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_CMP   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  function automatic int node_size(input int id_size, input int slots, input int addr_size);
    return id_size + slots * addr_size;
  endfunction

  // LSB of child slot k; the identifier occupies the bottom of the word.
  function automatic int child_lsb(input int k, input int id_size, input int addr_size);
    return id_size + k * addr_size;
  endfunction
endpackage

// File: rtl/user_tree_pkg.sv
// User-tunable tree geometry: identifier width and child slots per node.
package user_tree_pkg;
  localparam int IDENTIFIER_SIZE     = 8;
  localparam int MAX_NODES_PER_LEVEL = 4;
endpackage

// File: rtl/tree_walker_stats.sv
// Saturating hit/miss counters, stepped once per response handshake.
module tree_walker_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resp_fire,
  input  logic        resp_hit,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_fire) begin
      if (resp_hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (!resp_hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
endmodule

// File: rtl/tree_walker.sv
// Walks a child-slot tree one identifier token at a time, reporting hit/miss per token.
// Define TREE_WALKER_STATS_EN to add the hit_count/miss_count outputs.
//   state | meaning
//   IDLE  | waiting for a token
//   FETCH | read current node
//   SCAN  | test child slot k, read the child if present
//   CMP   | compare child id against the token
//   RESP  | hold the result until match_ready
module tree_walker
  import tree_pkg::*;
#(
  parameter int IDENTIFIER_SIZE     = user_tree_pkg::IDENTIFIER_SIZE,
  parameter int MAX_NODES_PER_LEVEL = user_tree_pkg::MAX_NODES_PER_LEVEL,
  parameter int NODE_ADDR_SIZE      = tree_pkg::NODE_ADDR_SIZE,
  localparam int NODE_SIZE = tree_pkg::node_size(IDENTIFIER_SIZE, MAX_NODES_PER_LEVEL, NODE_ADDR_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tok_valid,
  output logic                       tok_ready,
  input  logic [IDENTIFIER_SIZE-1:0] tok_id,
  input  logic                       tok_last,
  output logic                       node_rd_en,
  output logic [NODE_ADDR_SIZE-1:0]  node_rd_addr,
  input  logic [NODE_SIZE-1:0]       node_rd_data,
  output logic                       match_valid,
  input  logic                       match_ready,
  output logic                       match_hit,
`ifdef TREE_WALKER_STATS_EN
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count,
`endif
  output logic [NODE_ADDR_SIZE-1:0]  match_addr
);
  localparam int K_W = (MAX_NODES_PER_LEVEL > 1) ? $clog2(MAX_NODES_PER_LEVEL) : 1;

  logic [2:0]                 state;
  logic [K_W-1:0]             k;
  logic [NODE_ADDR_SIZE-1:0]  cur_addr;
  logic [IDENTIFIER_SIZE-1:0] id_q;
  logic                       last_q;
  logic [NODE_SIZE-1:0]       node_q;
  logic                       scan_first;
  logic [NODE_SIZE-1:0]       child_word;
  logic [NODE_ADDR_SIZE-1:0]  child_k;
  logic                       id_match;
  logic                       resp_fire;

  // The first SCAN cycle sees the fetched node straight off the bus while it is captured.
  assign child_word = scan_first ? node_rd_data : node_q;
  assign child_k    = child_word[child_lsb(int'(k), IDENTIFIER_SIZE, NODE_ADDR_SIZE) +: NODE_ADDR_SIZE];
  assign id_match   = (node_rd_data[IDENTIFIER_SIZE-1:0] == id_q) && (id_q != '0);

  assign tok_ready    = (state == ST_IDLE);
  assign node_rd_en   = (state == ST_FETCH) || ((state == ST_SCAN) && (child_k != '0));
  assign node_rd_addr = (state == ST_FETCH) ? cur_addr : child_k;
  assign resp_fire    = (state == ST_RESP) && match_valid && match_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      k           <= '0;
      cur_addr    <= '0;
      id_q        <= '0;
      last_q      <= 1'b0;
      node_q      <= '0;
      scan_first  <= 1'b0;
      match_valid <= 1'b0;
      match_hit   <= 1'b0;
      match_addr  <= '0;
    end else begin
      scan_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tok_valid) begin
            id_q   <= tok_id;
            last_q <= tok_last;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          k          <= '0;
          scan_first <= 1'b1;
          state      <= ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_first)
            node_q <= node_rd_data;
          if (child_k == '0) begin
            match_hit  <= 1'b0;
            match_addr <= cur_addr;
            state      <= ST_RESP;
          end else begin
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          if (id_match) begin
            match_hit   <= 1'b1;
            match_addr  <= child_k;
            match_valid <= 1'b1;
            state       <= ST_RESP;
          end else if (k == K_W'(MAX_NODES_PER_LEVEL - 1)) begin
            match_hit  <= 1'b0;
            match_addr <= cur_addr;
            state      <= ST_RESP;
          end else begin
            k     <= k + 1'b1;
            state <= ST_SCAN;
          end
        end
        ST_RESP: begin
          // A miss publishes one cycle after entering RESP; a hit is already valid on entry.
          if (!match_valid) begin
            match_valid <= 1'b1;
          end else if (match_ready) begin
            match_valid <= 1'b0;
            if (last_q)
              cur_addr <= '0;
            else if (match_hit)
              cur_addr <= match_addr;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TREE_WALKER_STATS_EN
  tree_walker_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .resp_fire  (resp_fire),
    .resp_hit   (match_hit),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif
endmodule

// File: tb/tb_tree_walker.sv
// Directed plus randomized checking of tree_walker against a slot-list reference model.
module tb_tree_walker;
  localparam int IDW = user_tree_pkg::IDENTIFIER_SIZE;
  localparam int M   = user_tree_pkg::MAX_NODES_PER_LEVEL;
  localparam int AW  = tree_pkg::NODE_ADDR_SIZE;
  localparam int NW  = IDW + M * AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic [IDW-1:0] tok_id = '0;
  logic          tok_last = 1'b0;
  logic          node_rd_en;
  logic [AW-1:0] node_rd_addr;
  logic [NW-1:0] node_rd_data = '0;
  logic          match_valid;
  logic          match_ready = 1'b0;
  logic          match_hit;
  logic [AW-1:0] match_addr;
`ifdef TREE_WALKER_STATS_EN
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
`endif

  logic [NW-1:0] mem [256];
  logic [AW-1:0] m_cur;
  int            m_hits, m_miss;
  int            n_checks = 0;
  int            n_fail = 0;

  tree_walker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_id       (tok_id),
    .tok_last     (tok_last),
    .node_rd_en   (node_rd_en),
    .node_rd_addr (node_rd_addr),
    .node_rd_data (node_rd_data),
    .match_valid  (match_valid),
    .match_ready  (match_ready),
    .match_hit    (match_hit),
`ifdef TREE_WALKER_STATS_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .match_addr   (match_addr)
  );

  always #5 clk = ~clk;

  // Synchronous-read tree memory: data appears the cycle after the strobe.
  always @(posedge clk)
    if (node_rd_en) node_rd_data <= mem[node_rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk_node(input logic [IDW-1:0] id, input logic [AW-1:0] c0,
                                            input logic [AW-1:0] c1);
    logic [NW-1:0] w;
    w = '0;
    w[IDW-1:0] = id;
    w[IDW +: AW] = c0;
    if (M > 1) w[IDW + AW +: AW] = c1;
    return w;
  endfunction

  // Reference: first non-empty slot whose node id equals the token wins; an empty slot ends the search.
  task automatic model(input logic [AW-1:0] cur, input logic [IDW-1:0] id,
                       output bit hit, output logic [AW-1:0] addr, output int lat);
    bit done;
    logic [AW-1:0] ch;
    hit = 0; addr = cur; lat = 2 + 2 * M; done = 0;
    for (int s = 0; s < M; s++) begin
      if (!done) begin
        ch = mem[cur][IDW + s * AW +: AW];
        if (ch == '0) begin
          lat = 3 + 2 * s; done = 1;
        end else if (id != '0 && mem[ch][IDW-1:0] == id) begin
          hit = 1; addr = ch; lat = 3 + 2 * s; done = 1;
        end
      end
    end
  endtask

  task automatic run_tok(input string tag, input logic [IDW-1:0] id, input logic last, input int hold);
    bit e_hit, got;
    logic [AW-1:0] e_addr;
    int e_lat, lat;
    model(m_cur, id, e_hit, e_addr, e_lat);
    @(negedge clk);
    chk({tag, ".tok_ready"}, tok_ready, 1);
    tok_valid = 1; tok_id = id; tok_last = last;
    @(posedge clk);
    #1 tok_valid = 0;
    got = 0; lat = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(posedge clk);
      #1;
      if (match_valid) begin got = 1; lat = c; end
    end
    if (!got) begin
      chk({tag, ".timeout"}, 0, 1);
      return;
    end
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".hit"}, match_hit, e_hit);
    chk({tag, ".addr"}, match_addr, e_addr);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, match_valid, 1);
      chk({tag, ".hold_hit"}, match_hit, e_hit);
      chk({tag, ".hold_addr"}, match_addr, e_addr);
      chk({tag, ".hold_ready"}, tok_ready, 0);
    end
    @(negedge clk) match_ready = 1;
    @(posedge clk);
    #1 match_ready = 0;
    if (last) m_cur = '0;
    else if (e_hit) m_cur = e_addr;
    if (e_hit) m_hits++; else m_miss++;
    chk({tag, ".valid_drop"}, match_valid, 0);
    chk({tag, ".idle"}, tok_ready, 1);
    chk({tag, ".cur_addr"}, dut.cur_addr, m_cur);
  endtask

  initial begin
    bit e_hit;
    logic [AW-1:0] e_addr, ch;
    int e_lat;
    logic [IDW-1:0] id;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[0] = mk_node(8'd0, 8'd1, 8'd2);
    mem[1] = mk_node(8'd5, 8'd2, 8'd0);
    mem[2] = mk_node(8'd7, 8'd0, 8'd0);
    m_cur = '0; m_hits = 0; m_miss = 0;

    #1;
    chk("rst.valid", match_valid, 0);
    chk("rst.rd_en", node_rd_en, 0);
    chk("rst.cur_addr", dut.cur_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1 chk("rst.tok_ready", tok_ready, 1);

    run_tok("t7", 8'd7, 1'b0, 0);
    run_tok("t9", 8'd9, 1'b0, 0);
    run_tok("t9last", 8'd9, 1'b1, 0);
    run_tok("t5last_hold", 8'd5, 1'b1, 4);
    run_tok("t0", 8'd0, 1'b0, 1);
    run_tok("t5", 8'd5, 1'b0, 0);

    // From node 1, token 7 reaches CMP two cycles after acceptance; reset there.
    @(negedge clk);
    tok_valid = 1; tok_id = 8'd7; tok_last = 0;
    @(posedge clk);
    #1 tok_valid = 0;
    @(posedge clk);
    #1;
    chk("scan.rd_en", node_rd_en, 1);
    chk("scan.rd_addr", node_rd_addr, 2);
    @(posedge clk);
    #1 chk("cmp.rd_en", node_rd_en, 0);
    #1 rst_n = 0;
    #1;
    chk("midrst.valid", match_valid, 0);
    chk("midrst.cur_addr", dut.cur_addr, 0);
    @(negedge clk) rst_n = 1;
    m_cur = '0; m_hits = 0; m_miss = 0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("postrst.no_resp", match_valid, 0);
    end
    chk("postrst.tok_ready", tok_ready, 1);
    run_tok("t5_root", 8'd5, 1'b0, 0);
    model(8'd0, 8'd5, e_hit, e_addr, e_lat);
    chk("model.root5_lat", e_lat, 3);

    // Random trees of 32 nodes; tokens lean towards ids present among the current node's children.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 32; a++) begin
        int nch;
        mem[a] = '0;
        mem[a][IDW-1:0] = IDW'($urandom_range(15, 0));
        nch = $urandom_range(M, 0);
        for (int s = 0; s < nch; s++) mem[a][IDW + s * AW +: AW] = AW'($urandom_range(31, 1));
      end
      for (int t = 0; t < 15; t++) begin
        if ($urandom_range(9, 0) < 6) begin
          ch = mem[m_cur][IDW + $urandom_range(M - 1, 0) * AW +: AW];
          id = (ch != '0) ? mem[ch][IDW-1:0] : IDW'($urandom_range(15, 0));
        end else begin
          id = IDW'($urandom_range(15, 0));
        end
        run_tok($sformatf("rnd%0d_%0d", r, t), id, ($urandom_range(4, 0) == 0), $urandom_range(2, 0));
      end
    end

`ifdef TREE_WALKER_STATS_EN
    chk("stats.hit_count", hit_count, m_hits);
    chk("stats.miss_count", miss_count, m_miss);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
